// File: rtl/spi_lcd_init_sequencer_if.sv
// Bus bundle between the LCD init sequencer and its neighbours: the init ROM,
// the chip-select SPI master's TX port, the panel control pins and the pixel stream.
// The sequencer takes the master modport; the slave modport is the view of
// the blocks it talks to.
interface spi_lcd_init_sequencer_if #(
    parameter int ROM_ADDR_W = 6
);
    logic [ROM_ADDR_W-1:0] o_Rom_Addr;
    logic [9:0]            i_Rom_Data;
    logic [7:0]            o_TX_Byte;
    logic                  o_TX_DV;
    logic [1:0]            o_TX_Count;
    logic                  i_TX_Ready;
    logic                  o_LCD_DC;
    logic                  o_LCD_Rst_n;
    logic [7:0]            i_Pix_Byte;
    logic                  i_Pix_DV;
    logic                  o_Pix_Ready;
    logic                  o_Init_Done;
    logic                  i_Restart;

    modport master (
        output o_Rom_Addr,
        input  i_Rom_Data,
        output o_TX_Byte,
        output o_TX_DV,
        output o_TX_Count,
        input  i_TX_Ready,
        output o_LCD_DC,
        output o_LCD_Rst_n,
        input  i_Pix_Byte,
        input  i_Pix_DV,
        output o_Pix_Ready,
        output o_Init_Done,
        input  i_Restart
    );

    modport slave (
        input  o_Rom_Addr,
        output i_Rom_Data,
        input  o_TX_Byte,
        input  o_TX_DV,
        input  o_TX_Count,
        output i_TX_Ready,
        input  o_LCD_DC,
        input  o_LCD_Rst_n,
        output i_Pix_Byte,
        output i_Pix_DV,
        input  o_Pix_Ready,
        input  o_Init_Done,
        output i_Restart
    );
endinterface

// File: rtl/spi_lcd_init_sequencer.sv
// LCD init sequencer: pulses the panel hardware reset, walks an init ROM of
// CMD/DATA/DELAY/END entries feeding the SPI master one byte per chip-select,
// drives D/C for each byte, then hands the SPI master over to the pixel stream.
// It is the only writer of the SPI master's TX port.
module spi_lcd_init_sequencer #(
    parameter int ROM_ADDR_W      = 6,
    parameter int RST_LOW_CLKS    = 1000,
    parameter int RST_WAIT_CLKS   = 5000,
    parameter int DELAY_UNIT_CLKS = 1000
) (
    input logic                    i_Clk,
    input logic                    i_Rst_L,
    spi_lcd_init_sequencer_if.master bus
);

    // One shared counter serves the reset pulse, the post-reset wait and DELAY entries,
    // so it is sized for the largest of the three.
    localparam int DELAY_MAX = 255 * DELAY_UNIT_CLKS;
    localparam int RST_MAX   = (RST_LOW_CLKS > RST_WAIT_CLKS) ? RST_LOW_CLKS : RST_WAIT_CLKS;
    localparam int CNT_MAX   = (DELAY_MAX > RST_MAX) ? DELAY_MAX : RST_MAX;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(RST_LOW_CLKS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RST_WAIT_CLKS - 1);
    localparam logic [CNT_W-1:0] DELAY_UNIT = CNT_W'(DELAY_UNIT_CLKS);

    localparam logic [2:0] ST_RST_LOW  = 3'd0;
    localparam logic [2:0] ST_RST_WAIT = 3'd1;
    localparam logic [2:0] ST_FETCH    = 3'd2;
    localparam logic [2:0] ST_DECODE   = 3'd3;
    localparam logic [2:0] ST_SEND     = 3'd4;
    localparam logic [2:0] ST_WAIT_TX  = 3'd5;
    localparam logic [2:0] ST_DELAY    = 3'd6;
    localparam logic [2:0] ST_STREAM   = 3'd7;

    localparam logic [1:0] TYPE_CMD   = 2'b00;
    localparam logic [1:0] TYPE_DATA  = 2'b01;
    localparam logic [1:0] TYPE_DELAY = 2'b10;
    localparam logic [1:0] TYPE_END   = 2'b11;

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [7:0]            tx_byte;
    logic                  tx_dv;
    logic                  lcd_dc;
    logic                  lcd_rst_n;
    logic                  init_done;
    logic                  mask;
    logic                  dc_pend;
    logic                  restart_pend;

    logic [1:0]            rom_type;
    logic [7:0]            rom_arg;
    logic                  last_addr;
    logic                  tx_idle;
    logic                  pix_ready;
    logic                  pix_accept;

    assign rom_type   = bus.i_Rom_Data[9:8];
    assign rom_arg    = bus.i_Rom_Data[7:0];
    assign last_addr  = (rom_addr == {ROM_ADDR_W{1'b1}});

    // The master counts as idle only once it reports ready and we are neither
    // pulsing DV nor inside the cycle right after a pulse, where ready may be stale.
    assign tx_idle    = bus.i_TX_Ready & ~mask & ~tx_dv;
    assign pix_ready  = (state == ST_STREAM) & tx_idle & ~restart_pend;
    assign pix_accept = pix_ready & bus.i_Pix_DV;

    assign bus.o_Rom_Addr  = rom_addr;
    assign bus.o_TX_Byte   = tx_byte;
    assign bus.o_TX_DV     = tx_dv;
    assign bus.o_TX_Count  = 2'd1;
    assign bus.o_LCD_DC    = lcd_dc;
    assign bus.o_LCD_Rst_n = lcd_rst_n;
    assign bus.o_Pix_Ready = pix_ready;
    assign bus.o_Init_Done = init_done;

    // Sequencer FSM: panel reset, ROM walk, byte issue, then pixel streaming.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= ST_RST_LOW;
            cnt          <= '0;
            rom_addr     <= '0;
            tx_byte      <= 8'h00;
            tx_dv        <= 1'b0;
            lcd_dc       <= 1'b0;
            lcd_rst_n    <= 1'b0;
            init_done    <= 1'b0;
            mask         <= 1'b0;
            dc_pend      <= 1'b0;
            restart_pend <= 1'b0;
        end else begin
            tx_dv <= 1'b0;
            case (state)
                ST_RST_LOW: begin
                    lcd_rst_n <= 1'b0;
                    init_done <= 1'b0;
                    if (cnt == LOW_LAST) begin
                        cnt       <= '0;
                        lcd_rst_n <= 1'b1;
                        state     <= ST_RST_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt      <= '0;
                        rom_addr <= '0;
                        state    <= ST_FETCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_FETCH: begin
                    state <= ST_DECODE;
                end

                ST_DECODE: begin
                    case (rom_type)
                        TYPE_CMD, TYPE_DATA: begin
                            tx_byte <= rom_arg;
                            dc_pend <= rom_type[0];
                            state   <= ST_SEND;
                        end
                        TYPE_DELAY: begin
                            cnt   <= CNT_W'(rom_arg) * DELAY_UNIT;
                            state <= ST_DELAY;
                        end
                        default: begin
                            init_done <= 1'b1;
                            state     <= ST_STREAM;
                        end
                    endcase
                end

                // D/C is applied together with the DV pulse so it only moves while the master is idle.
                ST_SEND: begin
                    if (bus.i_TX_Ready) begin
                        tx_dv  <= 1'b1;
                        lcd_dc <= dc_pend;
                        mask   <= 1'b1;
                        state  <= ST_WAIT_TX;
                    end
                end

                ST_WAIT_TX: begin
                    if (mask) begin
                        mask <= 1'b0;
                    end else if (bus.i_TX_Ready) begin
                        if (last_addr) begin
                            init_done <= 1'b1;
                            state     <= ST_STREAM;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end

                ST_DELAY: begin
                    if (cnt == '0) begin
                        if (last_addr) begin
                            init_done <= 1'b1;
                            state     <= ST_STREAM;
                        end else begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                // A restart that collides with a pixel accept waits until that byte has gone out.
                ST_STREAM: begin
                    mask <= tx_dv;
                    if (pix_accept) begin
                        tx_byte <= bus.i_Pix_Byte;
                        tx_dv   <= 1'b1;
                        lcd_dc  <= 1'b1;
                        if (bus.i_Restart) begin
                            restart_pend <= 1'b1;
                        end
                    end else if (tx_idle && (bus.i_Restart || restart_pend)) begin
                        state        <= ST_RST_LOW;
                        cnt          <= '0;
                        lcd_rst_n    <= 1'b0;
                        init_done    <= 1'b0;
                        lcd_dc       <= 1'b0;
                        restart_pend <= 1'b0;
                    end else begin
                        if (tx_idle) begin
                            lcd_dc <= 1'b1;
                        end
                        if (bus.i_Restart) begin
                            restart_pend <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_RST_LOW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_lcd_init_sequencer.sv
// Directed bench for spi_lcd_init_sequencer: a registered init ROM, a model SPI
// master that drops ready for a programmable time after each byte, and a monitor
// logging every DV pulse together with handshake-rule violations.
module tb_spi_lcd_init_sequencer;

    logic clk = 1'b0;
    logic rst_l = 1'b0;

    always #5 clk = ~clk;

    spi_lcd_init_sequencer_if #(.ROM_ADDR_W(6)) bus ();

    spi_lcd_init_sequencer #(
        .ROM_ADDR_W     (6),
        .RST_LOW_CLKS   (1000),
        .RST_WAIT_CLKS  (5000),
        .DELAY_UNIT_CLKS(1000)
    ) dut (
        .i_Clk  (clk),
        .i_Rst_L(rst_l),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_len = 8;
    int busy_cnt;

    logic [9:0] rom [0:63];

    logic [7:0] dv_byte_q[$];
    logic       dv_dc_q[$];
    int         dv_cyc_q[$];
    int         busy_dv = 0;
    int         close_dv = 0;
    int         dc_busy = 0;
    int         done_rise = 0;
    int         last_dv = 0;
    bit         have_last = 0;
    logic       prev_dc = 1'b0;
    logic       prev_done = 1'b0;

    // Registered init ROM: data valid one clock after the address.
    always @(posedge clk) begin
        bus.i_Rom_Data <= rom[bus.o_Rom_Addr];
    end

    // Model SPI master: takes a byte on DV, then stays busy for busy_len+1 clocks.
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bus.i_TX_Ready <= 1'b1;
            busy_cnt       <= 0;
        end else if (bus.o_TX_DV && bus.i_TX_Ready) begin
            bus.i_TX_Ready <= 1'b0;
            busy_cnt       <= busy_len;
        end else if (!bus.i_TX_Ready) begin
            if (busy_cnt == 0) bus.i_TX_Ready <= 1'b1;
            else busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge clk) cyc++;

    // Monitor sampled on the falling edge: logs DV pulses and rule violations.
    always @(negedge clk) begin
        if (rst_l) begin
            if (bus.o_TX_DV) begin
                dv_byte_q.push_back(bus.o_TX_Byte);
                dv_dc_q.push_back(bus.o_LCD_DC);
                dv_cyc_q.push_back(cyc);
                if (!bus.i_TX_Ready) busy_dv++;
                if (have_last && (cyc - last_dv) < 3) close_dv++;
                have_last = 1;
                last_dv = cyc;
            end
            if (bus.o_LCD_DC !== prev_dc && !bus.i_TX_Ready) dc_busy++;
            if (bus.o_Init_Done && !prev_done) done_rise = cyc;
        end
        prev_dc = bus.o_LCD_DC;
        prev_done = bus.o_Init_Done;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_log();
        dv_byte_q.delete();
        dv_dc_q.delete();
        dv_cyc_q.delete();
        have_last = 0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (bus.o_TX_Byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_byte: got %h expected 00", bus.o_TX_Byte); end
        checks++; if (bus.o_TX_DV !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_dv: got %b expected 0", bus.o_TX_DV); end
        checks++; if (bus.o_LCD_DC !== 1'b0) begin errors++; $display("[TB] FAIL reset_dc: got %b expected 0", bus.o_LCD_DC); end
        checks++; if (bus.o_LCD_Rst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_rst_n: got %b expected 0", bus.o_LCD_Rst_n); end
        checks++; if (bus.o_Pix_Ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_ready: got %b expected 0", bus.o_Pix_Ready); end
        checks++; if (bus.o_Init_Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_init_done: got %b expected 0", bus.o_Init_Done); end
        checks++; if (bus.o_Rom_Addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", bus.o_Rom_Addr); end
        checks++; if (bus.o_TX_Count !== 2'd1) begin errors++; $display("[TB] FAIL tx_count: got %0d expected 1", bus.o_TX_Count); end
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    // Entered while o_LCD_Rst_n is low, before the first clock of the low phase.
    task automatic test_reset_timing();
        int n;
        int rise;
        int guard;
        bit pr_seen;
        bit rn_low_seen;
        n = 0;
        pr_seen = 0;
        rn_low_seen = 0;
        while (bus.o_LCD_Rst_n === 1'b0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (n !== 1000) begin errors++; $display("[TB] FAIL rst_low_clks: got %0d expected 1000", n); end
        rise = cyc;
        repeat (100) @(posedge clk);
        #1;
        bus.i_Restart = 1'b1;
        bus.i_Pix_DV = 1'b1;
        bus.i_Pix_Byte = 8'hEE;
        @(posedge clk); #1;
        bus.i_Restart = 1'b0;
        guard = 0;
        while (dv_byte_q.size() == 0 && guard < 6000) begin
            @(negedge clk); #1;
            if (bus.o_Pix_Ready) pr_seen = 1;
            if (!bus.o_LCD_Rst_n) rn_low_seen = 1;
            guard++;
        end
        bus.i_Pix_DV = 1'b0;
        checks++; if (pr_seen) begin errors++; $display("[TB] FAIL pix_ready_during_init: got 1 expected 0"); end
        checks++; if (rn_low_seen) begin errors++; $display("[TB] FAIL restart_ignored: rst_n went low, expected high"); end
        checks++;
        if (dv_byte_q.size() == 0) begin
            errors++; $display("[TB] FAIL first_dv_timeout: got no DV expected byte 11");
        end else begin
            if ((dv_cyc_q[0] - rise) !== 5003) begin errors++; $display("[TB] FAIL first_fetch_delay: got %0d expected 5003", dv_cyc_q[0] - rise); end
            checks++; if (dv_byte_q[0] !== 8'h11 || dv_dc_q[0] !== 1'b0) begin errors++; $display("[TB] FAIL first_byte: got %h dc %b expected 11 dc 0", dv_byte_q[0], dv_dc_q[0]); end
        end
    endtask

    task automatic test_init_rom();
        int guard;
        int gap;
        logic [7:0] exp_b [3];
        logic       exp_dc [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h29; exp_b[2] = 8'h55;
        exp_dc[0] = 1'b0; exp_dc[1] = 1'b0; exp_dc[2] = 1'b1;
        guard = 0;
        while (bus.o_Init_Done !== 1'b1 && guard < 10000) begin
            @(negedge clk); #1; guard++;
        end
        checks++; if (bus.o_Init_Done !== 1'b1) begin errors++; $display("[TB] FAIL init_done_timeout: got %b expected 1", bus.o_Init_Done); end
        checks++; if (dv_byte_q.size() !== 3) begin errors++; $display("[TB] FAIL rom_byte_count: got %0d expected 3", dv_byte_q.size()); end
        if (dv_byte_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dv_byte_q[i] !== exp_b[i] || dv_dc_q[i] !== exp_dc[i]) begin
                    errors++; $display("[TB] FAIL rom_byte%0d: got %h dc %b expected %h dc %b", i, dv_byte_q[i], dv_dc_q[i], exp_b[i], exp_dc[i]);
                end
            end
            gap = dv_cyc_q[1] - dv_cyc_q[0];
            checks++; if (gap < 2000 || gap > 2100) begin errors++; $display("[TB] FAIL delay_gap: got %0d expected 2000..2100", gap); end
            checks++; if (done_rise < dv_cyc_q[2] + busy_len + 2) begin errors++; $display("[TB] FAIL done_after_last_byte: got cycle %0d expected >= %0d", done_rise, dv_cyc_q[2] + busy_len + 2); end
        end
        checks++; if (busy_dv !== 0) begin errors++; $display("[TB] FAIL dv_while_busy: got %0d expected 0", busy_dv); end
        checks++; if (close_dv !== 0) begin errors++; $display("[TB] FAIL dv_spacing: got %0d expected 0", close_dv); end
        checks++; if (dc_busy !== 0) begin errors++; $display("[TB] FAIL dc_change_busy: got %0d expected 0", dc_busy); end
    endtask

    task automatic test_stream();
        int k;
        int guard;
        bit acc;
        busy_len = 8;
        repeat (20) @(posedge clk);
        clear_log();
        @(posedge clk); #1;
        bus.i_Pix_Byte = 8'hA0;
        bus.i_Pix_DV = 1'b1;
        k = 0;
        guard = 0;
        while (k < 4 && guard < 1000) begin
            @(negedge clk); #1;
            acc = bus.o_Pix_Ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                bus.i_Pix_Byte = 8'hA0 + 8'(k);
            end
            guard++;
        end
        bus.i_Pix_DV = 1'b0;
        guard = 0;
        while (dv_byte_q.size() < 4 && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        checks++; if (dv_byte_q.size() !== 4) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 4", dv_byte_q.size()); end
        if (dv_byte_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dv_byte_q[i] !== 8'hA0 + 8'(i) || dv_dc_q[i] !== 1'b1) begin
                    errors++; $display("[TB] FAIL stream_byte%0d: got %h dc %b expected %h dc 1", i, dv_byte_q[i], dv_dc_q[i], 8'hA0 + 8'(i));
                end
            end
        end
        checks++; if (busy_dv !== 0 || close_dv !== 0) begin errors++; $display("[TB] FAIL stream_handshake: got busy %0d close %0d expected 0 0", busy_dv, close_dv); end
    endtask

    task automatic test_restart();
        repeat (20) @(posedge clk);
        busy_len = 49;
        clear_log();
        @(negedge clk);
        bus.i_Restart = 1'b1;
        @(posedge clk); #1;
        bus.i_Restart = 1'b0;
        checks++; if (bus.o_Init_Done !== 1'b0) begin errors++; $display("[TB] FAIL restart_done_low: got %b expected 0", bus.o_Init_Done); end
        checks++; if (bus.o_LCD_Rst_n !== 1'b0) begin errors++; $display("[TB] FAIL restart_rst_n: got %b expected 0", bus.o_LCD_Rst_n); end
        test_reset_timing();
        test_init_rom();
    endtask

    task automatic test_restart_with_accept();
        int guard;
        busy_len = 8;
        repeat (60) @(posedge clk);
        clear_log();
        guard = 0;
        do begin
            @(negedge clk); #1; guard++;
        end while (bus.o_Pix_Ready !== 1'b1 && guard < 200);
        bus.i_Pix_Byte = 8'hB7;
        bus.i_Pix_DV = 1'b1;
        bus.i_Restart = 1'b1;
        @(posedge clk); #1;
        bus.i_Pix_DV = 1'b0;
        bus.i_Restart = 1'b0;
        checks++; if (bus.o_Init_Done !== 1'b1) begin errors++; $display("[TB] FAIL coincide_done_held: got %b expected 1", bus.o_Init_Done); end
        guard = 0;
        while (dv_byte_q.size() == 0 && guard < 20) begin
            @(negedge clk); #1; guard++;
        end
        checks++;
        if (dv_byte_q.size() == 0) begin
            errors++; $display("[TB] FAIL coincide_byte: got no DV expected b7");
        end else if (dv_byte_q[0] !== 8'hB7 || dv_dc_q[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL coincide_byte: got %h dc %b expected b7 dc 1", dv_byte_q[0], dv_dc_q[0]);
        end
        guard = 0;
        while (bus.o_Init_Done !== 1'b0 && guard < 200) begin
            @(negedge clk); #1; guard++;
        end
        checks++; if (bus.o_Init_Done !== 1'b0 || bus.o_LCD_Rst_n !== 1'b0) begin errors++; $display("[TB] FAIL coincide_restart: got done %b rst_n %b expected 0 0", bus.o_Init_Done, bus.o_LCD_Rst_n); end
        checks++; if (dv_byte_q.size() !== 1) begin errors++; $display("[TB] FAIL coincide_dv_count: got %0d expected 1", dv_byte_q.size()); end
    endtask

    task automatic test_reset_mid_transfer();
        int guard;
        clear_log();
        guard = 0;
        while (dv_byte_q.size() < 3 && guard < 12000) begin
            @(negedge clk); #1; guard++;
        end
        checks++; if (dv_byte_q.size() < 3) begin errors++; $display("[TB] FAIL replay_bytes: got %0d expected 3", dv_byte_q.size()); end
        rst_l = 1'b0;
        #1;
        checks++; if (bus.o_TX_Byte !== 8'h00) begin errors++; $display("[TB] FAIL midrst_tx_byte: got %h expected 00", bus.o_TX_Byte); end
        checks++; if (bus.o_LCD_DC !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dc: got %b expected 0", bus.o_LCD_DC); end
        checks++; if (bus.o_Rom_Addr !== 6'd0) begin errors++; $display("[TB] FAIL midrst_rom_addr: got %0d expected 0", bus.o_Rom_Addr); end
        checks++; if (bus.o_LCD_Rst_n !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rst_n: got %b expected 0", bus.o_LCD_Rst_n); end
        checks++; if (bus.o_TX_DV !== 1'b0 || bus.o_Init_Done !== 1'b0 || bus.o_Pix_Ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags: got dv %b done %b pix_ready %b expected 0 0 0", bus.o_TX_DV, bus.o_Init_Done, bus.o_Pix_Ready); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear_log();
        rst_l = 1'b1;
        test_reset_timing();
        test_init_rom();
    endtask

    initial begin
        bus.i_Pix_DV = 1'b0;
        bus.i_Pix_Byte = 8'h00;
        bus.i_Restart = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 10'h3FF;
        rom[0] = {2'b00, 8'h11};
        rom[1] = {2'b10, 8'd2};
        rom[2] = {2'b00, 8'h29};
        rom[3] = {2'b01, 8'h55};
        rom[4] = {2'b11, 8'h00};

        $display("[TB] reset");
        test_reset();
        $display("[TB] reset release timing");
        test_reset_timing();
        $display("[TB] init ROM walk");
        test_init_rom();
        $display("[TB] pixel stream");
        test_stream();
        $display("[TB] restart with slow master");
        test_restart();
        $display("[TB] restart coinciding with pixel accept");
        test_restart_with_accept();
        $display("[TB] reset mid-transfer");
        test_reset_mid_transfer();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
